fp_f2i: RTL
===========

Name: fp_f2i

Overview:
- Pipelined floating-point to signed-integer converter; the inverse of fp_i2f.
- Sits at the CNN inference output stage and in the quantisation paths. It takes packed EXP/MANT floats and produces two's-complement integers.
- Rounds toward zero (C-cast semantics) and saturates on overflow.
- Fixed latency; accepts one sample per clock; no backpressure.

Parameters:
- EXP, 5, exponent field width
- MANT, 10, stored mantissa width (hidden bit implied)
- WIDTH, 1+EXP+MANT, packed float width
- IWIDTH, 16, signed integer result width (IWIDTH >= 2)

Ports:
- clock  in  1  rising-edge clock
- clock_areset_n  in  1  asynchronous active-low reset
- data_valid  in  1  dataa is valid this cycle
- dataa  in  WIDTH  packed float {sign, exp, mant}
- result_valid  out  1  result/overflow are valid this cycle
- result  out  IWIDTH  signed integer, two's complement
- overflow  out  1  set for out-of-range, Inf or NaN input; qualified by result_valid

Behaviour:
- Reset:
  - clock_areset_n low clears result_valid, result and overflow to 0 immediately, without waiting for a clock edge.
  - It also clears all internal valid bits and pipeline registers.
  - Samples in flight when reset asserts are discarded, and no result_valid is produced for them.
  - First sample accepted on the first rising edge after deassertion.
- Latency and throughput:
  - Exactly 3 clocks. A sample with data_valid=1 at edge N has result_valid=1 at edge N+3.
  - Back-to-back valid inputs give back-to-back outputs in order.
  - result and overflow hold their last value while result_valid=0. Nothing outside the valid cycles is checked.
- Constant: BIAS = 2^(EXP-1)-1.
- Stage 1, unpack and classify:
  - s = sign bit, e = exp field, m = mant field.
  - zero_sub = (e==0): zero and subnormals map to result 0, overflow 0.
  - special = (e==all-ones): m==0 is Inf, m!=0 is NaN.
  - Unbiased exponent ue = e-BIAS, held signed in EXP+1 bits.
  - Significand sig = {1,m}, MANT+1 bits.
- Stage 2, magnitude:
  - ue<0: mag=0.
  - ue > IWIDTH-1: range flag set.
  - Otherwise mag = (sig << ue) >> MANT, using a barrel shift with an intermediate width of at least MANT+IWIDTH bits. Truncation discards fraction bits, which is round-toward-zero.
  - ue == IWIDTH-1 is in range only when s=1 and m==0, i.e. exactly -2^(IWIDTH-1). Any other value with ue == IWIDTH-1 sets the range flag.
- Stage 3, sign and saturate:
  - NaN: result 0, overflow 1.
  - +Inf or positive range: result 2^(IWIDTH-1)-1, overflow 1.
  - -Inf or negative range: result -2^(IWIDTH-1), overflow 1.
  - Otherwise result = s ? -mag : mag, overflow 0.
  - Negative zero gives result 0.
- Arithmetic and width rules:
  - Negative results never wrap.
  - Values whose truncated magnitude is 0 give 0, never -0 artefacts.
  - Parameter combinations where 2^(EXP-1) < IWIDTH are legal; overflow then occurs only on Inf/NaN.
- No state machine. Control is the 3-deep valid shift register alongside the data pipe.

Test Plan (defaults EXP=5, MANT=10, IWIDTH=16; values in hex):
- Exact integers, one every other cycle, after reset:
  - 0xDBF8, 0xD800, 0xBC00, 0x0000, 0x3C00, 0x5800, 0x5BF8 -> results 0xFF01, 0xFF80, 0xFFFF, 0x0000, 0x0001, 0x0080, 0x00FF.
  - Each appears 3 clocks after its input; overflow 0 throughout.
  - This is the round-trip check against the fp_i2f stimulus set.
- Truncation and small values:
  - 0x4180 (2.75) -> 0x0002.
  - 0xC180 (-2.75) -> 0xFFFE.
  - 0x3800 (0.5) -> 0x0000.
  - 0x8001 (negative subnormal) -> 0x0000.
  - overflow 0 for all four.
- Saturation and specials:
  - 0xF800 (-32768) -> 0x8000, overflow 0.
  - 0x7800 (+32768) -> 0x7FFF, overflow 1.
  - 0x7BFF (65504) -> 0x7FFF, overflow 1.
  - 0x7C00 (+Inf) -> 0x7FFF, overflow 1.
  - 0xFC00 (-Inf) -> 0x8000, overflow 1.
  - 0x7E00 (NaN) -> 0x0000, overflow 1.
- Throughput:
  - 8 consecutive valid inputs with no gaps -> 8 consecutive result_valid cycles, in order, starting exactly 3 clocks after the first input.
  - A single-cycle data_valid gap in the input produces the same gap in result_valid.
- Reset mid-flight:
  - Assert clock_areset_n low between clock edges while 2 samples are in the pipe -> result_valid, result and overflow go to 0 immediately; no stale outputs after release.
  - The next input after release appears 3 clocks later with the correct value.

Source files
------------

// File: rtl/fp_f2i.sv
// Pipelined float -> signed integer converter: truncates toward zero and saturates
// on overflow. Three register stages, one sample per clock, no backpressure.
module fp_f2i #(
   parameter int EXP    = 5,
   parameter int MANT   = 10,
   parameter int WIDTH  = 1 + EXP + MANT,
   parameter int IWIDTH = 16
) (
   input  logic              clock,
   input  logic              clock_areset_n,
   input  logic              data_valid,
   input  logic [WIDTH-1:0]  dataa,
   output logic              result_valid,
   output logic [IWIDTH-1:0] result,
   output logic              overflow
);

   localparam int BIAS = 2**(EXP-1) - 1;
   localparam int SW   = MANT + IWIDTH;
   localparam logic [IWIDTH-1:0] IMAX = {1'b0, {(IWIDTH-1){1'b1}}};
   localparam logic [IWIDTH-1:0] IMIN = {1'b1, {(IWIDTH-1){1'b0}}};

   // valid shift register alongside the data pipe; bit 3 is the output stage
   logic [3:1] vld_pipe_q;

   // ---------------- stage 1: unpack and classify ----------------
   logic [EXP-1:0]  e_w;
   logic [MANT-1:0] m_w;
   logic            s1_d, zero1_d, spec1_d, mnz1_d;
   logic [EXP:0]    ue1_d;
   logic [MANT:0]   sig1_d;

   logic               s1_q, zero1_q, spec1_q, mnz1_q;
   logic signed [EXP:0] ue1_q;
   logic [MANT:0]      sig1_q;

   assign e_w     = dataa[WIDTH-2 -: EXP];
   assign m_w     = dataa[MANT-1:0];
   assign s1_d    = dataa[WIDTH-1];
   assign zero1_d = (e_w == '0);
   assign spec1_d = &e_w;
   assign mnz1_d  = |m_w;
   assign ue1_d   = {1'b0, e_w} - (EXP+1)'(BIAS);
   assign sig1_d  = {1'b1, m_w};

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         s1_q    <= 1'b0;
         zero1_q <= 1'b0;
         spec1_q <= 1'b0;
         mnz1_q  <= 1'b0;
         ue1_q   <= '0;
         sig1_q  <= '0;
      end else if (data_valid) begin
         s1_q    <= s1_d;
         zero1_q <= zero1_d;
         spec1_q <= spec1_d;
         mnz1_q  <= mnz1_d;
         ue1_q   <= ue1_d;
         sig1_q  <= sig1_d;
      end
   end

   // ---------------- stage 2: magnitude and range ----------------
   int              ue_i;
   logic [SW-1:0]   sh_w;
   logic [IWIDTH-1:0] mag2_d;
   logic            rng2_d;

   logic              s2_q, nan2_q, inf2_q, rng2_q;
   logic [IWIDTH-1:0] mag2_q;

   assign ue_i = int'(ue1_q);
   // only consulted when 0 <= ue <= IWIDTH-1, so the shifted value always fits
   assign sh_w = SW'(sig1_q) << ue1_q;

   always_comb begin
      mag2_d = '0;
      rng2_d = 1'b0;
      if (!zero1_q && !spec1_q) begin
         if (ue_i > IWIDTH-1)
            rng2_d = 1'b1;
         else if (ue_i == IWIDTH-1 && (!s1_q || mnz1_q))
            rng2_d = 1'b1;
         else if (ue_i >= 0)
            mag2_d = sh_w[MANT +: IWIDTH];
      end
   end

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         s2_q   <= 1'b0;
         nan2_q <= 1'b0;
         inf2_q <= 1'b0;
         rng2_q <= 1'b0;
         mag2_q <= '0;
      end else if (vld_pipe_q[1]) begin
         s2_q   <= s1_q;
         nan2_q <= spec1_q & mnz1_q;
         inf2_q <= spec1_q & ~mnz1_q;
         rng2_q <= rng2_d;
         mag2_q <= mag2_d;
      end
   end

   // ---------------- stage 3: sign and saturate ----------------
   logic [IWIDTH-1:0] result_d;
   logic              overflow_d;
   logic [IWIDTH-1:0] result_q;
   logic              overflow_q;

   // -2^(IWIDTH-1) magnitude negates onto itself, so no wrap for the in-range minimum
   always_comb begin
      result_d   = s2_q ? (~mag2_q + 1'b1) : mag2_q;
      overflow_d = 1'b0;
      if (nan2_q) begin
         result_d   = '0;
         overflow_d = 1'b1;
      end else if (inf2_q || rng2_q) begin
         result_d   = s2_q ? IMIN : IMAX;
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         vld_pipe_q <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[2:1], data_valid};
         if (vld_pipe_q[2]) begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
         end
      end
   end

   assign result_valid = vld_pipe_q[3];
   assign result       = result_q;
   assign overflow     = overflow_q;

endmodule
